// File: rtl/zero_restore_shifter_32bit.sv
// ---------------------------------------------------------------------------
// zero_restore_shifter_32bit
//
// Multi-cycle logical right shifter that re-inserts a counted number of
// leading zeros. It undoes a normalize-by-NLZ step: given the normalized
// word and its NLZ / all-zero pair it rebuilds the original operand
// (o_data = i_data >> i_nlz, or 0 when i_all_zero). The shift advances four
// bits per cycle while at least four remain, then one bit per cycle.
//
// Ports:
//   i_clk       - clock, all state updates on the rising edge
//   i_rst       - synchronous active-high reset
//   i_valid     - request valid
//   o_ready     - request can be accepted (IDLE only)
//   i_data      - word to denormalize
//   i_nlz       - number of zeros to insert at the MSB end (0..31)
//   i_all_zero  - source word was all zeros; result is forced to 0
//   o_valid     - result valid (DONE only)
//   i_ready     - downstream accepts the result
//   o_data      - result word, registered (shift register contents)
//   o_state     - current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer keeps valid and payload stable until that edge;
// the consumer's ready may change freely. o_ready and o_valid come straight
// from registers, never from inputs, and are never high together.
// ---------------------------------------------------------------------------
module zero_restore_shifter_32bit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_data,
    input  logic [4:0]  i_nlz,
    input  logic        i_all_zero,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_data,
    output logic [1:0]  o_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_NIBBLE = 2'd1;
    localparam logic [1:0] S_BIT    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] sh_q, sh_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  cnt_minus4;
    logic [4:0]  cnt_minus1;
    logic        accept;

    // Set while reset is applied so o_ready stays low during reset even
    // though the state register already reads IDLE.
    logic        in_rst_q;

    assign o_ready    = (state_q == S_IDLE) && !in_rst_q;
    assign o_valid    = (state_q == S_DONE);
    assign o_data     = sh_q;
    assign o_state    = state_q;
    assign accept     = i_valid && o_ready;

    // NIBBLE is only entered/kept with cnt >= 4 and BIT with cnt >= 1,
    // so neither subtraction can wrap.
    assign cnt_minus4 = cnt_q - 5'd4;
    assign cnt_minus1 = cnt_q - 5'd1;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (i_all_zero) begin
                        sh_d    = 32'd0;
                        cnt_d   = 5'd0;
                        state_d = S_DONE;
                    end else begin
                        sh_d  = i_data;
                        cnt_d = i_nlz;
                        if (i_nlz == 5'd0) begin
                            state_d = S_DONE;
                        end else if (i_nlz >= 5'd4) begin
                            state_d = S_NIBBLE;
                        end else begin
                            state_d = S_BIT;
                        end
                    end
                end
            end
            S_NIBBLE: begin
                sh_d  = {4'b0000, sh_q[31:4]};
                cnt_d = cnt_minus4;
                if (cnt_minus4 >= 5'd4) begin
                    state_d = S_NIBBLE;
                end else if (cnt_minus4 != 5'd0) begin
                    state_d = S_BIT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_BIT: begin
                sh_d  = {1'b0, sh_q[31:1]};
                cnt_d = cnt_minus1;
                if (cnt_minus1 == 5'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            sh_q     <= 32'd0;
            cnt_q    <= 5'd0;
            in_rst_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            in_rst_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zero_restore_shifter_32bit.sv
// ---------------------------------------------------------------------------
// Bench for zero_restore_shifter_32bit: directed vector table, corner-case
// sequences (reset during BIT, backpressure, busy-time requests) and a
// randomized run of normalized words checked against a reference shift.
// ---------------------------------------------------------------------------
module tb_zero_restore_shifter_32bit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready_dut;
    logic [31:0] in_data;
    logic [4:0]  in_nlz;
    logic        in_all_zero;
    logic        out_valid_dut;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_state;

    int total;
    int bad;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    typedef struct {
        logic [31:0] data;
        logic [4:0]  nlz;
        logic        all_zero;
        logic [31:0] exp_data;
        int          exp_lat;   // rising edges after the accept edge
    } vec_t;

    vec_t vecs[8];

    zero_restore_shifter_32bit dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (in_valid),
        .o_ready    (out_ready_dut),
        .i_data     (in_data),
        .i_nlz      (in_nlz),
        .i_all_zero (in_all_zero),
        .o_valid    (out_valid_dut),
        .i_ready    (in_ready),
        .o_data     (out_data),
        .o_state    (out_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int lzc(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return n;
            n++;
        end
        return n;
    endfunction

    // ready and valid must never be asserted together
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (out_ready_dut && out_valid_dut) begin
                bad++;
                $display("FAIL ready_valid_overlap: got 1 want 0 at %0t", $time);
            end
        end
    end

    // ---------------- driver / scoreboard ----------------
    // Issues one request, checks busy behaviour, latency and result, then
    // holds backpressure for hold_cycles before accepting the result.
    // With poke=1 a conflicting request and an early i_ready are applied
    // while the block is busy; both must be ignored.
    task automatic run_one(input logic [31:0] data, input logic [4:0] nlz,
                           input logic az, input logic [31:0] exp_data,
                           input int exp_lat, input int hold_cycles,
                           input bit poke, input bit check_lzc);
        int guard;
        int lat;
        logic [31:0] e;
        int el;
        bit seen;

        guard = 0;
        while (!out_ready_dut && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", {31'd0, out_ready_dut}, 32'd1);

        in_valid    = 1'b1;
        in_data     = data;
        in_nlz      = nlz;
        in_all_zero = az;
        exp_q.push_back(exp_data);
        lat_q.push_back(exp_lat);
        @(posedge clk);                 // accept edge

        lat  = 0;
        seen = 1'b0;
        @(negedge clk);
        if (poke) begin
            in_valid    = 1'b1;
            in_data     = ~data;
            in_nlz      = 5'd0;
            in_all_zero = ~az;
            in_ready    = 1'b1;
        end else begin
            in_valid = 1'b0;
            in_data  = $urandom;
        end
        while (lat <= 20) begin
            if (out_valid_dut) begin
                seen = 1'b1;
                break;
            end
            check("ready_low_busy", {31'd0, out_ready_dut}, 32'd0);
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("valid_seen", {31'd0, seen}, 32'd1);

        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        if (seen) begin
            check("latency", lat, el);
            check("o_data", out_data, e);
            if (check_lzc) check("lzc_out", lzc(out_data), {27'd0, nlz});
            if (!poke) begin
                for (int h = 0; h < hold_cycles; h++) begin
                    @(negedge clk);
                    check("hold_valid", {31'd0, out_valid_dut}, 32'd1);
                    check("hold_data", out_data, e);
                end
            end
            in_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_ready = 1'b0;
            check("valid_drop", {31'd0, out_valid_dut}, 32'd0);
            check("ready_back", {31'd0, out_ready_dut}, 32'd1);
        end else begin
            in_ready = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [4:0]  n;
        int          guard;
        bit          spurious;

        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 32'd0;
        in_nlz      = 5'd0;
        in_all_zero = 1'b0;
        in_ready    = 1'b0;

        vecs[0] = '{32'h8000_0001, 5'd0,  1'b0, 32'h8000_0001, 0};
        vecs[1] = '{32'hF000_0000, 5'd7,  1'b0, 32'h01E0_0000, 4};
        vecs[2] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 10};
        vecs[3] = '{32'hDEAD_BEEF, 5'd5,  1'b1, 32'h0000_0000, 0};
        vecs[4] = '{32'h1234_5678, 5'd4,  1'b0, 32'h0123_4567, 1};
        vecs[5] = '{32'hFFFF_FFFF, 5'd3,  1'b0, 32'h1FFF_FFFF, 3};
        vecs[6] = '{32'hA5A5_A5A5, 5'd16, 1'b0, 32'h0000_A5A5, 4};
        vecs[7] = '{32'h8000_0000, 5'd8,  1'b0, 32'h0080_0000, 2};

        // reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, out_ready_dut}, 32'd0);
        check("rst_valid", {31'd0, out_valid_dut}, 32'd0);
        check("rst_data", out_data, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_ready", {31'd0, out_ready_dut}, 32'd1);
        check("idle_valid", {31'd0, out_valid_dut}, 32'd0);
        check("idle_data", out_data, 32'd0);

        // directed table
        for (int i = 0; i < 8; i++) begin
            run_one(vecs[i].data, vecs[i].nlz, vecs[i].all_zero,
                    vecs[i].exp_data, vecs[i].exp_lat, 0, 1'b0, (i == 2));
        end

        // backpressure: result held for 4 cycles
        run_one(32'hC000_0000, 5'd6, 1'b0, 32'h0300_0000, 3, 4, 1'b0, 1'b1);

        // new request and early i_ready while busy are ignored
        run_one(32'h9ABC_DEF0, 5'd13, 1'b0, 32'h0004_D5E6, 4, 0, 1'b1, 1'b0);
        run_one(32'h8765_4321, 5'd2,  1'b0, 32'h21D9_50C8, 2, 0, 1'b1, 1'b0);

        // reset for 3 cycles while in BIT aborts the request
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = 32'hF000_0000;
        in_nlz      = 5'd3;
        in_all_zero = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("in_bit_state", {30'd0, out_state}, 32'd2);
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_ready", {31'd0, out_ready_dut}, 32'd0);
            check("abort_valid", {31'd0, out_valid_dut}, 32'd0);
            check("abort_data", out_data, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready_back", {31'd0, out_ready_dut}, 32'd1);
        spurious = 1'b0;
        for (int r = 0; r < 12; r++) begin
            if (out_valid_dut) spurious = 1'b1;
            @(negedge clk);
        end
        check("abort_no_valid", {31'd0, spurious}, 32'd0);

        // randomized normalized words
        for (int t = 0; t < 1000; t++) begin
            d = {1'b1, 31'($urandom)};
            n = 5'($urandom_range(0, 31));
            run_one(d, n, 1'b0, d >> n, (n / 4) + (n % 4),
                    $urandom_range(0, 2), 1'b0, 1'b1);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 1) guard++;
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
